// File: rtl/kb_pkg.sv
// Shared constants, prefix-state enum and scan-code translation
// for the PS/2 set-2 ASCII decoder.
package kb_pkg;

    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_LSHIFT      = 8'h12;
    localparam logic [7:0] SC_RSHIFT      = 8'h59;
    localparam logic [7:0] SC_CAPS        = 8'h58;
    localparam logic [7:0] ASCII_UNMAPPED = 8'h2A;

    typedef enum logic [1:0] {
        S_MAKE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } kb_state_e;

    typedef struct packed {
        logic       hit;
        logic [7:0] ch;
    } xlat_t;

    function automatic xlat_t scan2ascii(
        input logic [7:0] code,
        input logic       ext,
        input logic       upper_letters,
        input logic       shifted
    );
        xlat_t      r;
        logic [7:0] ltr;
        r.hit = 1'b1;
        r.ch  = 8'h00;
        ltr   = 8'h00;
        if (ext) begin
            case (code)
                8'h5A:   r.ch = 8'h0D;
                8'h75:   r.ch = 8'h38;
                8'h72:   r.ch = 8'h32;
                8'h74:   r.ch = 8'h36;
                8'h6B:   r.ch = 8'h34;
                default: r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h1C: ltr = 8'h41;
                8'h32: ltr = 8'h42;
                8'h21: ltr = 8'h43;
                8'h23: ltr = 8'h44;
                8'h24: ltr = 8'h45;
                8'h2B: ltr = 8'h46;
                8'h34: ltr = 8'h47;
                8'h33: ltr = 8'h48;
                8'h43: ltr = 8'h49;
                8'h3B: ltr = 8'h4A;
                8'h42: ltr = 8'h4B;
                8'h4B: ltr = 8'h4C;
                8'h3A: ltr = 8'h4D;
                8'h31: ltr = 8'h4E;
                8'h44: ltr = 8'h4F;
                8'h4D: ltr = 8'h50;
                8'h15: ltr = 8'h51;
                8'h2D: ltr = 8'h52;
                8'h1B: ltr = 8'h53;
                8'h2C: ltr = 8'h54;
                8'h3C: ltr = 8'h55;
                8'h2A: ltr = 8'h56;
                8'h1D: ltr = 8'h57;
                8'h22: ltr = 8'h58;
                8'h35: ltr = 8'h59;
                8'h1A: ltr = 8'h5A;
                8'h16: r.ch = shifted ? 8'h21 : 8'h31;
                8'h1E: r.ch = shifted ? 8'h40 : 8'h32;
                8'h26: r.ch = shifted ? 8'h23 : 8'h33;
                8'h25: r.ch = shifted ? 8'h24 : 8'h34;
                8'h2E: r.ch = shifted ? 8'h25 : 8'h35;
                8'h36: r.ch = shifted ? 8'h5E : 8'h36;
                8'h3D: r.ch = shifted ? 8'h26 : 8'h37;
                8'h3E: r.ch = shifted ? 8'h2A : 8'h38;
                8'h46: r.ch = shifted ? 8'h28 : 8'h39;
                8'h45: r.ch = shifted ? 8'h29 : 8'h30;
                8'h0E: r.ch = shifted ? 8'h7E : 8'h60;
                8'h4E: r.ch = shifted ? 8'h5F : 8'h2D;
                8'h55: r.ch = shifted ? 8'h2B : 8'h3D;
                8'h54: r.ch = shifted ? 8'h7B : 8'h5B;
                8'h5B: r.ch = shifted ? 8'h7D : 8'h5D;
                8'h5D: r.ch = shifted ? 8'h7C : 8'h5C;
                8'h4C: r.ch = shifted ? 8'h3A : 8'h3B;
                8'h52: r.ch = shifted ? 8'h22 : 8'h27;
                8'h41: r.ch = shifted ? 8'h3C : 8'h2C;
                8'h49: r.ch = shifted ? 8'h3E : 8'h2E;
                8'h4A: r.ch = shifted ? 8'h3F : 8'h2F;
                8'h29: r.ch = 8'h20;
                8'h5A: r.ch = 8'h0D;
                8'h66: r.ch = 8'h08;
                8'h75: r.ch = 8'h38;
                8'h72: r.ch = 8'h32;
                8'h74: r.ch = 8'h36;
                8'h6B: r.ch = 8'h34;
                default: r.hit = 1'b0;
            endcase
            // Letters share one base table; case is applied afterwards
            if (ltr != 8'h00) begin
                r.ch = upper_letters ? ltr : ltr + 8'h20;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/kb_fifo.sv
// Show-ahead FIFO, 8-bit wide, 2**ADDR_W entries.
// Full accepts a push when a pop happens in the same cycle.
module kb_fifo #(
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic            rd_ok, wr_ok;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W])
                && (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign rd_data = empty ? 8'h00 : mem_q[rptr_q[ADDR_W-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            mem_d[wptr_q[ADDR_W-1:0]] = wr_data;
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/kb_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder: prefix FSM, modifier
// tracking and overflow flag in front of a show-ahead FIFO.
module kb_ascii_decoder
    import kb_pkg::*;
#(
    parameter int ADDR_W        = 2,
    parameter bit LOWERCASE_EN  = 1'b1,
    parameter bit DROP_UNMAPPED = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_en,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_active,
    output logic       caps_active
);

    kb_state_e  state_q, state_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic       caps_held_q, caps_held_d;
    logic       ovf_q, ovf_d;
    logic       done, brk, ext, push, upper;
    logic       is_pfx;
    logic [7:0] push_data;
    xlat_t      xl;

    assign shift_active = lshift_q | rshift_q;
    assign caps_active  = caps_q;
    assign overflow     = ovf_q;
    assign is_pfx       = (rx_data == SC_EXT) || (rx_data == SC_BREAK);
    assign upper        = !LOWERCASE_EN || (shift_active ^ caps_q);
    assign xl = scan2ascii(rx_data, ext, upper, shift_active);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        brk     = 1'b0;
        ext     = 1'b0;
        if (rx_done_tick) begin
            unique case (state_q)
                S_MAKE: begin
                    if (rx_data == SC_EXT)        state_d = S_EXT;
                    else if (rx_data == SC_BREAK) state_d = S_BRK;
                    else                          done = 1'b1;
                end
                S_EXT: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = S_EXT_BRK;
                    end else if (rx_data != SC_EXT) begin
                        done    = 1'b1;
                        ext     = 1'b1;
                        state_d = S_MAKE;
                    end
                end
                S_BRK: begin
                    if (!is_pfx) begin
                        done    = 1'b1;
                        brk     = 1'b1;
                        state_d = S_MAKE;
                    end
                end
                S_EXT_BRK: begin
                    if (!is_pfx) begin
                        done    = 1'b1;
                        brk     = 1'b1;
                        ext     = 1'b1;
                        state_d = S_MAKE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        push        = 1'b0;
        push_data   = 8'h00;
        if (done) begin
            if (rx_data == SC_LSHIFT) begin
                lshift_d = !brk;
            end else if (rx_data == SC_RSHIFT) begin
                rshift_d = !brk;
            end else if (rx_data == SC_CAPS) begin
                // Held-key latch stops typematic repeat from re-toggling
                if (brk) begin
                    caps_held_d = 1'b0;
                end else begin
                    if (!caps_held_q) caps_d = !caps_q;
                    caps_held_d = 1'b1;
                end
            end else if (!brk) begin
                if (xl.hit) begin
                    push      = 1'b1;
                    push_data = xl.ch;
                end else if (!ext && !DROP_UNMAPPED) begin
                    push      = 1'b1;
                    push_data = ASCII_UNMAPPED;
                end
            end
        end
        ovf_d = push && full && !rd_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_MAKE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            ovf_q       <= ovf_d;
        end
    end

    kb_fifo #(
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push),
        .wr_data(push_data),
        .rd_en  (rd_en),
        .rd_data(ascii_out),
        .empty  (empty),
        .full   (full)
    );

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// Scoreboard bench for kb_ascii_decoder: stimulus pushes expected
// characters, a monitor pops them as the FIFO presents data.
module tb_kb_ascii_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [7:0] ascii_out;
    logic       empty, full, overflow, shift_active, caps_active;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       drain = 1'b0;

    always #5 clk = ~clk;

    kb_ascii_decoder #(
        .ADDR_W(2),
        .LOWERCASE_EN(1'b1),
        .DROP_UNMAPPED(1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .ascii_out   (ascii_out),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .shift_active(shift_active),
        .caps_active (caps_active)
    );

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic make(input logic [7:0] b, input logic [7:0] e);
        exp_q.push_back(e);
        send(b);
    endtask

    task automatic set_drain(input logic v);
        @(posedge clk);
        #1 drain = v;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({name, "_left"}, 8'(exp_q.size()), 8'h00);
        chk({name, "_empty"}, 8'(empty), 8'h01);
    endtask

    // Monitor: pops and compares whenever data is presented
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (drain && !reset && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char got=%h exp=none",
                             ascii_out);
                end else begin
                    chk("fifo_head", ascii_out, exp_q.pop_front());
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_empty", 8'(empty), 8'h01);
        chk("rst_full", 8'(full), 8'h00);
        chk("rst_ovf", 8'(overflow), 8'h00);
        chk("rst_shift", 8'(shift_active), 8'h00);
        chk("rst_caps", 8'(caps_active), 8'h00);
        chk("rst_ascii", ascii_out, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // 'a' appears one cycle after its tick; break pushes nothing
        chk("t1_empty_before", 8'(empty), 8'h01);
        send(8'h1C);
        chk("t1_empty_after", 8'(empty), 8'h00);
        chk("t1_head", ascii_out, 8'h61);
        exp_q.push_back(8'h61);
        send(8'hF0);
        send(8'h1C);
        set_drain(1'b1);
        wait_drain("t1");

        // Shift
        send(8'h12);
        chk("t2_shift_on", 8'(shift_active), 8'h01);
        make(8'h16, 8'h21);
        make(8'h4E, 8'h5F);
        make(8'h29, 8'h20);
        chk("t2_shift_held", 8'(shift_active), 8'h01);
        send(8'hF0);
        send(8'h12);
        chk("t2_shift_off", 8'(shift_active), 8'h00);
        make(8'h16, 8'h31);
        make(8'h52, 8'h27);
        send(8'h59);
        chk("t2_rshift_on", 8'(shift_active), 8'h01);
        make(8'h5D, 8'h7C);
        send(8'hF0);
        send(8'h59);
        chk("t2_rshift_off", 8'(shift_active), 8'h00);
        wait_drain("t2");

        // Caps Lock with typematic repeat
        send(8'h58);
        chk("t3_caps_on", 8'(caps_active), 8'h01);
        send(8'h58);
        chk("t3_caps_repeat", 8'(caps_active), 8'h01);
        send(8'hF0);
        send(8'h58);
        make(8'h1C, 8'h41);
        make(8'h16, 8'h31);
        send(8'h12);
        make(8'h1C, 8'h61);
        send(8'hF0);
        send(8'h12);
        send(8'h58);
        chk("t3_caps_off", 8'(caps_active), 8'h00);
        send(8'hF0);
        send(8'h58);
        make(8'h1A, 8'h7A);
        wait_drain("t3");

        // Extended prefixes and unmapped code
        send(8'hE0);
        make(8'h75, 8'h38);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        make(8'h07, 8'h2A);
        send(8'hE0);
        make(8'h5A, 8'h0D);
        send(8'hE0);
        send(8'h1C);
        make(8'h6B, 8'h34);
        wait_drain("t4");

        // Full, overflow, then push+pop while full
        set_drain(1'b0);
        make(8'h16, 8'h31);
        make(8'h1E, 8'h32);
        make(8'h26, 8'h33);
        chk("t5_not_full3", 8'(full), 8'h00);
        make(8'h25, 8'h34);
        chk("t5_full", 8'(full), 8'h01);
        chk("t5_ovf_before", 8'(overflow), 8'h00);
        send(8'h2E);
        chk("t5_ovf_pulse", 8'(overflow), 8'h01);
        chk("t5_head", ascii_out, 8'h31);
        @(negedge clk);
        chk("t5_ovf_clear", 8'(overflow), 8'h00);
        chk("t5_still_full", 8'(full), 8'h01);
        set_drain(1'b1);
        make(8'h36, 8'h36);
        chk("t5_pp_full", 8'(full), 8'h01);
        chk("t5_pp_ovf", 8'(overflow), 8'h00);
        wait_drain("t5");

        // Reset mid-sequence with buffered characters
        set_drain(1'b0);
        send(8'h12);
        send(8'h58);
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        chk("t6_pre_empty", 8'(empty), 8'h00);
        send(8'hE0);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_empty", 8'(empty), 8'h01);
        chk("t6_shift", 8'(shift_active), 8'h00);
        chk("t6_caps", 8'(caps_active), 8'h00);
        chk("t6_full", 8'(full), 8'h00);
        reset = 1'b0;
        set_drain(1'b1);
        make(8'h1C, 8'h61);
        wait_drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
